// File: rtl/input_debounce_sync.sv
// rtl/input_debounce_sync.sv - synchroniser plus debounce filter for a raw asynchronous control input
// Optional glitch counter (glitch_cnt/glitch_clr) is built when DEBOUNCE_GLITCH_COUNT_EN is defined.
module input_debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    input  logic        glitch_clr,
    output logic [15:0] glitch_cnt,
`endif
    output logic        out,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in};
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != out_q) begin
                    state_d = PENDING;
                    cnt_d   = CW'(1);
                end
            end
            PENDING: begin
                if (s == out_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    out_d   = s;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        // busy is registered next to the state so it is a flop output, never a decode
        busy_d = (state_d == PENDING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= STABLE;
            cnt_q   <= '0;
            out_q   <= RESET_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
    logic        glitch_ev;
    logic [15:0] glitch_cnt_q, glitch_cnt_d;

    // a PENDING exit with s back at out is a rejected glitch
    assign glitch_ev = (state_q == PENDING) && (s == out_q);

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_ev && (glitch_cnt_q != 16'hFFFF)) begin
            glitch_cnt_d = glitch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// tb/tb_input_debounce_sync.sv - self-checking bench for input_debounce_sync
module tb_input_debounce_sync;
    localparam int SS = 2;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_r;
    logic        clr_r;
    logic        out_w;
    logic        busy_w;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    logic [15:0] glitch_cnt_w;
`endif

    always #5 clk = ~clk;

    input_debounce_sync #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_r),
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        .glitch_clr(clr_r),
        .glitch_cnt(glitch_cnt_w),
`endif
        .out       (out_w),
        .busy      (busy_w)
    );

    int chk = 0;
    int err = 0;

    // reference: s is in delayed SS cycles; out flips after DC+1 consecutive mismatching samples
    bit pipe_m[SS];
    bit out_m;
    int run_m;
    int glitch_m;

    typedef struct {
        bit i;
        bit o;
        bit b;
    } vec_t;
    vec_t tbl[$];

    task automatic model_reset();
        for (int k = 0; k < SS; k++) pipe_m[k] = 1'b0;
        out_m    = 1'b0;
        run_m    = 0;
        glitch_m = 0;
    endtask

    task automatic model_edge(input bit din, input bit clr);
        bit s_old;
        s_old = pipe_m[SS-1];
        for (int k = SS - 1; k > 0; k--) pipe_m[k] = pipe_m[k-1];
        pipe_m[0] = din;
        if (s_old != out_m) begin
            run_m++;
            if (run_m == DC + 1) begin
                out_m = s_old;
                run_m = 0;
            end
        end else begin
            if (run_m > 0 && glitch_m < 65535) glitch_m++;
            run_m = 0;
        end
        if (clr) glitch_m = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(in_r, clr_r);
        #1;
    endtask

    task automatic tick_check(input string name);
        tick();
        check({name, "_out"}, {31'd0, out_w}, {31'd0, out_m});
        check({name, "_busy"}, {31'd0, busy_w}, {31'd0, run_m > 0});
    endtask

    task automatic do_reset(input bit lvl);
        reset = 1'b1;
        in_r  = lvl;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // drives in=1 and counts edges until out rises; a timeout leaves n at the bound
    task automatic measure_rise(input string name, output int n);
        in_r = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick_check(name);
            n++;
            if (out_w === 1'b1) break;
        end
    endtask

    task automatic add(input bit i, input bit o, input bit b);
        vec_t v;
        v.i = i; v.o = o; v.b = b;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        int toggles;
        bit prev;
        bit lvl;
        int hold;

        reset = 1'b1;
        in_r  = 1'b0;
        clr_r = 1'b0;
        model_reset();

        // reset held with in=1: out and busy stay at reset values
        in_r = 1'b1;
        #1;
        check("rst_out", {31'd0, out_w}, 32'd0);
        check("rst_busy", {31'd0, busy_w}, 32'd0);
        repeat (3) begin
            tick();
            check("rst_hold_out", {31'd0, out_w}, 32'd0);
            check("rst_hold_busy", {31'd0, busy_w}, 32'd0);
        end
        reset = 1'b0;
        measure_rise("rel", n);
        check("rel_latency", n, 7);

        // table: clean rise, long hold, clean fall, 3-cycle pulse
        do_reset(1'b0);
        add(1, 0, 0); add(1, 0, 0); add(1, 0, 1); add(1, 0, 1);
        add(1, 0, 1); add(1, 0, 1); add(1, 1, 0); add(1, 1, 0);
        for (int k = 0; k < 12; k++) add(1, 1, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 1, 1); add(0, 1, 1);
        add(0, 1, 1); add(0, 1, 1); add(0, 0, 0); add(0, 0, 0);
        add(1, 0, 0); add(1, 0, 0); add(1, 0, 1); add(0, 0, 1);
        add(0, 0, 1); add(0, 0, 0); add(0, 0, 0); add(0, 0, 0);
        add(0, 0, 0);
        foreach (tbl[k]) begin
            in_r = tbl[k].i;
            tick();
            check($sformatf("tbl%0d_out", k), {31'd0, out_w}, {31'd0, tbl[k].o});
            check($sformatf("tbl%0d_busy", k), {31'd0, busy_w}, {31'd0, tbl[k].b});
        end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        check("tbl_glitch_cnt", {16'd0, glitch_cnt_w}, 32'd1);
`endif

        // bounce every 2 cycles, ending low, then settle high
        do_reset(1'b0);
        toggles = 0;
        prev = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_r = ((c / 2) % 2 == 1);
            tick_check("bounce");
            if (out_w !== prev) toggles++;
            prev = out_w;
        end
        measure_rise("settle", n);
        check("settle_latency", n, 7);
        if (out_w !== prev) toggles++;
        prev = out_w;
        repeat (10) begin
            tick_check("settle_hold");
            if (out_w !== prev) toggles++;
            prev = out_w;
        end
        check("bounce_toggles", toggles, 1);

        // reset during qualification at cnt=3
        do_reset(1'b0);
        in_r = 1'b1;
        repeat (5) tick_check("abort_pre");
        check("abort_busy_pre", {31'd0, busy_w}, 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("abort_out", {31'd0, out_w}, 32'd0);
        check("abort_busy", {31'd0, busy_w}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        measure_rise("abort_rel", n);
        check("abort_latency", n, 7);

        // randomized levels against the reference model
        do_reset(1'b0);
        for (int r = 0; r < 400; r++) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                in_r  = lvl;
                clr_r = ($urandom_range(0, 49) == 0);
                tick_check("rand");
`ifdef DEBOUNCE_GLITCH_COUNT_EN
                check("rand_glitch", {16'd0, glitch_cnt_w}, glitch_m);
`endif
            end
        end
        clr_r = 1'b0;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
        do_reset(1'b0);
        for (int g = 0; g < 70000; g++) begin
            in_r = 1'b1;
            tick();
            in_r = 1'b0;
            tick();
        end
        repeat (4) tick();
        check("sat_glitch", {16'd0, glitch_cnt_w}, 32'h0000FFFF);
        in_r = 1'b1;
        tick();
        in_r = 1'b0;
        tick();
        tick();
        check("clr_busy", {31'd0, busy_w}, 32'd1);
        clr_r = 1'b1;
        tick();
        clr_r = 1'b0;
        check("clr_glitch", {16'd0, glitch_cnt_w}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
